// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage:
// function codes, FSM state encoding and default widths.
package mem_access_stage_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_REG_W   = 3;
    localparam int DEF_TIMEOUT = 15;

    localparam logic [3:0] FN_LDD = 4'b0001;
    localparam logic [3:0] FN_STD = 4'b0010;
    localparam logic [3:0] FN_ADD = 4'b0011;
    localparam logic [3:0] FN_NOT = 4'b0100;
    localparam logic [3:0] FN_NOP = 4'b0101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // True for the codes that go out to data memory
    function automatic logic is_mem_op(input logic [3:0] f);
        return (f == FN_LDD) || (f == FN_STD);
    endfunction

    // True for the codes whose result may be written back
    function automatic logic is_wb_op(input logic [3:0] f);
        return (f == FN_ADD) || (f == FN_NOT);
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// Memory stage: registers ALU results to writeback and runs LDD/STD
// over a req/ack data-memory port, stalling upstream meanwhile.
// Optional watchdog abort on slow memory: define MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic              wb_en_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              valid_out,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_access_stage: TIMEOUT must be at least 1");
    end

    state_t           state;
    logic [REG_W-1:0] cap_reg;
    logic             cap_wb;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    assign mem_err = 1'b0;
`endif

    // Stage FSM with registered handshake and writeback outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            stall     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid_out <= 1'b0;
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            cap_reg   <= '0;
            cap_wb    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err   <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            valid_out <= 1'b0;
            wb_en     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err   <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (valid_in && is_mem_op(func)) begin
                        state     <= ST_ACCESS;
                        stall     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= (func == FN_STD);
                        mem_addr  <= alu_out[ADDR_W-1:0];
                        mem_wdata <= store_data;
                        cap_reg   <= dest_reg;
                        cap_wb    <= wb_en_in;
`ifdef MEM_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end else if (valid_in) begin
                        valid_out <= 1'b1;
                        wb_data   <= alu_out;
                        wb_reg    <= dest_reg;
                        wb_en     <= wb_en_in & is_wb_op(func);
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        state     <= ST_IDLE;
                        stall     <= 1'b0;
                        mem_req   <= 1'b0;
                        valid_out <= 1'b1;
                        wb_reg    <= cap_reg;
                        wb_en     <= cap_wb & ~mem_we;
                        wb_data   <= mem_we ? '0 : mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= ST_IDLE;
                        stall     <= 1'b0;
                        mem_req   <= 1'b0;
                        valid_out <= 1'b1;
                        mem_err   <= 1'b1;
                        wb_reg    <= cap_reg;
                    end else begin
                        to_cnt    <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a latency-programmable
// memory responder and a writeback monitor checking queued results.
`timescale 1ns/1ps
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  func;
    logic [15:0] alu_out;
    logic [15:0] store_data;
    logic [2:0]  dest_reg;
    logic        wb_en_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        valid_out;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        mem_err;

    mem_access_stage #(
        .DATA_W (16),
        .ADDR_W (16),
        .REG_W  (3),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .func      (func),
        .alu_out   (alu_out),
        .store_data(store_data),
        .dest_reg  (dest_reg),
        .wb_en_in  (wb_en_in),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .valid_out (valid_out),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rg;
        logic        chkreg;
        logic        en;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          mem_lat = 0;
    int          acc_n = 0;
    logic [15:0] rd_val = '0;
    logic        stray_ack = 1'b0;
    logic [15:0] last_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: acks after mem_lat request cycles (0 = never)
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            acc_n++;
            mem_ack   = (mem_lat != 0) && (acc_n == mem_lat);
            mem_rdata = mem_ack ? rd_val : 16'($urandom);
        end else begin
            acc_n     = 0;
            mem_ack   = stray_ack;
            mem_rdata = 16'($urandom);
        end
    end

    // Writeback monitor: pops one scoreboard entry per valid_out
    always @(negedge clk) begin
        if (rst && valid_out) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("vo_cycle", 32'(cyc), 32'(e.cyc));
                chk("wb_data", 32'(wb_data), 32'(e.data));
                chk("wb_en", 32'(wb_en), 32'(e.en));
                chk("mem_err", 32'(mem_err), 32'(e.err));
                chk("vo_stall", 32'(stall), 32'd0);
                if (e.chkreg) chk("wb_reg", 32'(wb_reg), 32'(e.rg));
            end
        end else if (rst) begin
            chk("pulse_idle", 32'({wb_en, mem_err}), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_vo"}, 32'(valid_out), 0);
        chk({tag, "_wben"}, 32'(wb_en), 0);
        chk({tag, "_wbreg"}, 32'(wb_reg), 0);
        chk({tag, "_wbdata"}, 32'(wb_data), 0);
        chk({tag, "_err"}, 32'(mem_err), 0);
    endtask

    // Present one instruction at posedge+1, hold it while stalled
    task automatic issue(input logic [3:0] f, input logic [15:0] a,
                         input logic [15:0] sd, input logic [2:0] d,
                         input logic wen, input int lat,
                         input logic [15:0] rd);
        exp_t e;
        logic mem;
        int   len;
        int   n;
        mem = (f == FN_LDD) || (f == FN_STD);
        len = !mem ? 0 : (lat == 0 ? TO : lat);
        e.cyc    = cyc + 1 + len;
        e.rg     = d;
        e.chkreg = 1'b1;
        e.err    = 1'b0;
        if (!mem) begin
            e.data = a;
            e.en   = wen && (f == FN_ADD || f == FN_NOT);
        end else if (lat == 0) begin
            e.data   = last_data;
            e.en     = 1'b0;
            e.err    = 1'b1;
            e.chkreg = 1'b0;
        end else if (f == FN_STD) begin
            e.data   = '0;
            e.en     = 1'b0;
            e.chkreg = 1'b0;
        end else begin
            e.data = rd;
            e.en   = wen;
        end
        last_data = e.data;
        sbq.push_back(e);
        mem_lat    = lat;
        rd_val     = rd;
        valid_in   = 1'b1;
        func       = f;
        alu_out    = a;
        store_data = sd;
        dest_reg   = d;
        wb_en_in   = wen;
        tick();
        n = 0;
        while (stall && n < 60) begin
            n++;
            chk("acc_req", 32'(mem_req), 32'd1);
            chk("acc_addr", 32'(mem_addr), 32'(a));
            chk("acc_we", 32'(mem_we), 32'(f == FN_STD));
            chk("acc_wdata", 32'(mem_wdata), 32'(sd));
            tick();
        end
        chk("stall_len", 32'(n), 32'(len));
        chk("req_after", 32'(mem_req), 32'd0);
        valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        valid_in = 1'b0;
        func = '0;
        alu_out = '0;
        store_data = '0;
        dest_reg = '0;
        wb_en_in = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        chk_zero("reset");
        tick();
        rst = 1'b1;
        tick();

        issue(FN_ADD, 16'h1234, 16'h0000, 3'd5, 1'b1, 0, 16'h0);
        tick();
        issue(FN_LDD, 16'h0040, 16'h0000, 3'd3, 1'b1, 3, 16'hBEEF);
        tick();
        issue(FN_STD, 16'h0010, 16'hA5A5, 3'd2, 1'b1, 1, 16'h0);
        tick();
        issue(FN_LDD, 16'h0080, 16'h1111, 3'd6, 1'b1, 2, 16'h1357);
        issue(FN_ADD, 16'h4321, 16'h0000, 3'd7, 1'b1, 0, 16'h0);
        issue(FN_NOT, 16'h00FF, 16'h0000, 3'd1, 1'b1, 0, 16'h0);
        issue(FN_NOP, 16'h7777, 16'h0000, 3'd4, 1'b1, 0, 16'h0);
        issue(4'hF,   16'h2222, 16'h0000, 3'd3, 1'b1, 0, 16'h0);
        issue(FN_ADD, 16'h9999, 16'h0000, 3'd2, 1'b0, 0, 16'h0);
        issue(FN_LDD, 16'h0F00, 16'h0000, 3'd1, 1'b0, 1, 16'hC0DE);

        stray_ack = 1'b1;
        tick();
        tick();
        stray_ack = 1'b0;
        chk("stray_ack_req", 32'(mem_req), 32'd0);
        chk("stray_ack_stall", 32'(stall), 32'd0);
        tick();

`ifdef MEM_TIMEOUT_EN
        issue(FN_LDD, 16'h0100, 16'h0000, 3'd5, 1'b1, 0, 16'h0);
        tick();
`endif

        mem_lat = 0;
        valid_in = 1'b1;
        func = FN_LDD;
        alu_out = 16'h0200;
        dest_reg = 3'd6;
        wb_en_in = 1'b1;
        tick();
        tick();
        chk("rst_acc_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk_zero("rst_access");
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_in = 1'b0;
        repeat (6) tick();
        chk("post_rst_req", 32'(mem_req), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
